// File: rtl/bit_serial_ctrl_if.sv
// Handshake and control bundle between the instruction front end and bit_serial_ctrl.
// The optional single-step input is present only when CTRL_STEP_EN is defined.
interface bit_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             start;
  logic [3:0]       opcode;
`ifdef CTRL_STEP_EN
  logic             step;
`endif
  logic             busy;
  logic             done;
  logic             illegal;
  logic             load_a;
  logic             load_b;
  logic             imm_sel;
  logic             shift_en;
  logic [1:0]       alu_op;
  logic             invert_b;
  logic             carry_init;
  logic             carry_val;
  logic             carry_en;
  logic             load_out;
  logic [CNT_W-1:0] bit_idx;

`ifdef CTRL_STEP_EN
  modport master (
    output start, opcode, step,
    input  busy, done, illegal, load_a, load_b, imm_sel, shift_en, alu_op,
           invert_b, carry_init, carry_val, carry_en, load_out, bit_idx
  );
  modport slave (
    input  start, opcode, step,
    output busy, done, illegal, load_a, load_b, imm_sel, shift_en, alu_op,
           invert_b, carry_init, carry_val, carry_en, load_out, bit_idx
  );
`else
  modport master (
    output start, opcode,
    input  busy, done, illegal, load_a, load_b, imm_sel, shift_en, alu_op,
           invert_b, carry_init, carry_val, carry_en, load_out, bit_idx
  );
  modport slave (
    input  start, opcode,
    output busy, done, illegal, load_a, load_b, imm_sel, shift_en, alu_op,
           invert_b, carry_init, carry_val, carry_en, load_out, bit_idx
  );
`endif
endinterface

// File: rtl/bit_serial_ctrl.sv
// Control FSM for the bit-serial CPU datapath: IDLE -> LOAD_A -> LOAD_B -> EXEC x WIDTH -> WRITE.
// Optional macro CTRL_STEP_EN: EXEC advances only on the step input (single-step debug).
module bit_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  bit_serial_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
      4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    case (op)
      4'b0001, 4'b1001: is_sub = 1'b1;
      default:          is_sub = 1'b0;
    endcase
  endfunction

  function automatic logic is_addsub(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b1000, 4'b1001: is_addsub = 1'b1;
      default:                            is_addsub = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    case (op)
      4'b0110, 4'b1100: alu_sel = 2'b01;
      4'b0101, 4'b1011: alu_sel = 2'b10;
      4'b0100, 4'b1010: alu_sel = 2'b11;
      default:          alu_sel = 2'b00;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             illegal_r;
  logic             advance_s;
  logic             accept_s;
  logic             load_a_s, load_b_s, imm_sel_s, shift_en_s, invert_b_s;
  logic             carry_init_s, carry_val_s, carry_en_s, load_out_s, done_s;

  // EXEC advance qualifier: every cycle, or only on step when single-stepping
  always_comb begin
`ifdef CTRL_STEP_EN
    advance_s = bus.step;
`else
    advance_s = 1'b1;
`endif
    accept_s = (state_r == ST_IDLE) && bus.start && is_legal(bus.opcode);
  end

  // Next-state and Moore strobe decode from state register and latched opcode
  always_comb begin
    state_s      = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    imm_sel_s    = 1'b0;
    shift_en_s   = 1'b0;
    invert_b_s   = 1'b0;
    carry_init_s = 1'b0;
    carry_val_s  = 1'b0;
    carry_en_s   = 1'b0;
    load_out_s   = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_LOAD_A;
        else          state_s = ST_IDLE;
      end
      ST_LOAD_A: begin
        load_a_s = 1'b1;
        state_s  = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        load_b_s     = 1'b1;
        imm_sel_s    = op_r[3];
        carry_init_s = 1'b1;
        carry_val_s  = is_sub(op_r);
        state_s      = ST_EXEC;
      end
      ST_EXEC: begin
        shift_en_s = advance_s;
        carry_en_s = advance_s & is_addsub(op_r);
        invert_b_s = is_sub(op_r);
        if (advance_s && (cnt_r == LAST_IDX)) state_s = ST_WRITE;
        else                                  state_s = ST_EXEC;
      end
      ST_WRITE: begin
        load_out_s = 1'b1;
        done_s     = 1'b1;
        state_s    = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, opcode latch, bit counter and illegal-opcode flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 4'b0000;
      cnt_r     <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      illegal_r <= (state_r == ST_IDLE) && bus.start && !is_legal(bus.opcode);
      if (accept_s) op_r <= bus.opcode;
      else          op_r <= op_r;
      // counter rests at zero outside EXEC and wraps back to zero on the last bit
      if (state_r != ST_EXEC)        cnt_r <= '0;
      else if (!advance_s)           cnt_r <= cnt_r;
      else if (cnt_r == LAST_IDX)    cnt_r <= '0;
      else                           cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.alu_op     = (state_r != ST_IDLE) ? alu_sel(op_r) : 2'b00;
  assign bus.illegal    = illegal_r;
  assign bus.done       = done_s;
  assign bus.load_a     = load_a_s;
  assign bus.load_b     = load_b_s;
  assign bus.imm_sel    = imm_sel_s;
  assign bus.shift_en   = shift_en_s;
  assign bus.invert_b   = invert_b_s;
  assign bus.carry_init = carry_init_s;
  assign bus.carry_val  = carry_val_s;
  assign bus.carry_en   = carry_en_s;
  assign bus.load_out   = load_out_s;
  assign bus.bit_idx    = cnt_r;
endmodule

// File: tb/tb_bit_serial_ctrl.sv
// Directed self-checking bench for bit_serial_ctrl with WIDTH=8.
// Cycle k is the interval after rising edge k; outputs are sampled 1 time unit after the edge.
module tb_bit_serial_ctrl;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;

  bit_serial_ctrl_if #(.WIDTH(8)) bus ();

  bit_serial_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy,done,illegal,load_a,load_b,imm_sel,shift_en,alu_op,invert_b,carry_init,carry_val,carry_en,load_out,bit_idx}
  function automatic logic [31:0] mk(input logic b, input logic d, input logic il, input logic la,
                                      input logic lb, input logic im, input logic sh, input logic [1:0] ao,
                                      input logic iv, input logic ci, input logic cv, input logic ce,
                                      input logic lo, input logic [2:0] bi);
    mk = {15'd0, b, d, il, la, lb, im, sh, ao, iv, ci, cv, ce, lo, bi};
  endfunction

  function automatic logic [31:0] obs_vec();
    obs_vec = {15'd0, bus.busy, bus.done, bus.illegal, bus.load_a, bus.load_b, bus.imm_sel,
               bus.shift_en, bus.alu_op, bus.invert_b, bus.carry_init, bus.carry_val,
               bus.carry_en, bus.load_out, bus.bit_idx};
  endfunction

  // Issue one instruction from an IDLE cycle and check every cycle 1..11.
  // restart_c: cycle in which start is pulsed again; abort_c: cycle in which rst is asserted.
  task automatic run_op(input string tag, input logic [3:0] op, input logic imm, input logic cv,
                        input logic inv, input logic cen, input logic [1:0] aop,
                        input int restart_c, input int abort_c);
    logic [31:0] e;
    bus.start  = 1'b1;
    bus.opcode = op;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 1)       e = mk(I,O,O,I,O,O,O,aop,O,O,O,O,O,3'd0);
      else if (c == 2)  e = mk(I,O,O,O,I,imm,O,aop,O,I,cv,O,O,3'd0);
      else if (c <= 10) e = mk(I,O,O,O,O,O,I,aop,inv,O,O,cen,O,3'(c - 3));
      else              e = mk(I,I,O,O,O,O,O,aop,O,O,O,O,I,3'd0);
      chk($sformatf("%s_c%0d", tag, c), obs_vec(), e);
      if (c == abort_c) begin
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        chk($sformatf("%s_rst", tag), obs_vec(), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        chk($sformatf("%s_rst_drop", tag), obs_vec(), 32'd0);
        return;
      end
      bus.start = (c == restart_c);
      if (c < 11) tick();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.opcode = 4'b0000;
`ifdef CTRL_STEP_EN
    bus.step   = 1'b1;
`endif
    tick();
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("reset", obs_vec(), 32'd0);
    tick();
    chk("reset_idle", obs_vec(), 32'd0);

    // ADD
    run_op("add", 4'b0000, O, O, O, I, 2'b00, 0, 0);
    tick();
    chk("add_c12", obs_vec(), 32'd0);

    // SUBI
    run_op("subi", 4'b1001, I, I, I, I, 2'b00, 0, 0);
    tick();
    chk("subi_c12", obs_vec(), 32'd0);

    // illegal opcode, then XOR
    bus.start  = 1'b1;
    bus.opcode = 4'b0111;
    tick();
    bus.start = 1'b0;
    chk("ill_c1", obs_vec(), mk(O,O,I,O,O,O,O,2'b00,O,O,O,O,O,3'd0));
    tick();
    chk("ill_c2", obs_vec(), 32'd0);
    run_op("xor", 4'b0110, O, O, O, O, 2'b01, 0, 0);
    tick();

    // assorted logic ops
    run_op("ori", 4'b1010, I, O, O, O, 2'b11, 0, 0);
    tick();
    run_op("and", 4'b0101, O, O, O, O, 2'b10, 0, 0);
    tick();
    run_op("sub", 4'b0001, O, I, I, I, 2'b00, 0, 0);
    tick();

    // start while busy is ignored; start in cycle 12 accepted
    run_op("busy_start", 4'b0000, O, O, O, I, 2'b00, 5, 0);
    tick();
    chk("busy_start_c12", obs_vec(), 32'd0);
    run_op("after_busy", 4'b1011, I, O, O, O, 2'b10, 0, 0);
    tick();

    // reset in EXEC at bit_idx 3, then a clean run
    run_op("abort", 4'b0001, O, I, I, I, 2'b00, 0, 6);
    run_op("post_rst", 4'b1100, I, O, O, O, 2'b01, 0, 0);
    tick();
    chk("post_rst_c12", obs_vec(), 32'd0);

`ifdef CTRL_STEP_EN
    begin
      int exp_idx;
      int nsh;
      exp_idx = 0;
      nsh     = 0;
      bus.start  = 1'b1;
      bus.opcode = 4'b0000;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 60 && !bus.done; k++) begin
        bus.step = (k % 3 == 2);
        #1;
        chk("step_idx", 32'(bus.bit_idx), 32'(exp_idx));
        if (bus.shift_en) nsh++;
        if (bus.step) exp_idx++;
        tick();
      end
      bus.step = 1'b1;
      chk("step_done", 32'(bus.done), 32'd1);
      chk("step_shifts", 32'(nsh), 32'd8);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bit_serial_ctrl.md
Name: bit_serial_ctrl

Overview:
Parametrised control FSM for the bit-serial CPU datapath. It supersedes the fixed 8-bit sequencer by adding an internal bit counter sized from WIDTH, full output decode, SUB carry/invert control, immediate operand sourcing, a busy/done handshake and illegal-opcode reporting. It sits between the instruction/button front end and the serial operand/ALU/output shift registers.

Parameters:
WIDTH, 8, operand width in bits; number of EXEC cycles; legal range 2..64.
CNT_W, $clog2(WIDTH), localparam; width of bit_idx.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle request; sampled only in IDLE.
opcode  in  4  instruction opcode; sampled with start.
busy  out  1  high from LOAD_A through WRITE inclusive.
done  out  1  one-cycle pulse in WRITE.
illegal  out  1  one-cycle pulse in the cycle after start with an illegal opcode.
load_a  out  1  parallel-load operand A shift register.
load_b  out  1  parallel-load operand B shift register.
imm_sel  out  1  B load source: 1 = immediate field, 0 = register.
shift_en  out  1  shift A, B and OUT registers by one bit.
alu_op  out  2  00 add/sub, 01 xor, 10 and, 11 or.
invert_b  out  1  invert serial B bit (SUB/SUBI).
carry_init  out  1  load the carry flop with carry_val.
carry_val  out  1  carry seed: 1 for SUB/SUBI, else 0.
carry_en  out  1  update the carry flop from the ALU each EXEC bit.
load_out  out  1  commit the result to the output register.
bit_idx  out  CNT_W  current bit position, LSB first.

Behaviour:
- Opcode map: R-type 0000 ADD, 0001 SUB, 0100 OR, 0101 AND, 0110 XOR. I-type 1000 ADDI, 1001 SUBI, 1010 ORI, 1011 ANDI, 1100 XORI. All other codes are illegal.
- opcode is latched into op_q when start is accepted. Every decode below uses op_q, never the live opcode input.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE.
- IDLE:
  - start=1 with a legal opcode: latch op_q, go to LOAD_A.
  - start=1 with an illegal opcode: stay in IDLE, illegal=1 in the following cycle, op_q unchanged.
  - start=0: stay in IDLE.
- LOAD_A: load_a=1. Always go to LOAD_B.
- LOAD_B: load_b=1, imm_sel=op_q[3], carry_init=1, carry_val as defined in Ports. Clear the bit counter. Go to EXEC.
- EXEC:
  - shift_en=1.
  - carry_en=1 only for the ADD/SUB family.
  - invert_b=1 only for SUB/SUBI.
  - bit_idx counts 0..WIDTH-1, incrementing each cycle.
  - At bit_idx==WIDTH-1, go to WRITE.
- WRITE: load_out=1, done=1. Go to IDLE.
- Timing, with start sampled at edge 0:
  - LOAD_A in cycle 1, LOAD_B in cycle 2.
  - EXEC in cycles 3..WIDTH+2.
  - WRITE in cycle WIDTH+3.
  - Total latency WIDTH+3 cycles. Next start is accepted in cycle WIDTH+4.
- alu_op is held from op_q for the whole of LOAD_A..WRITE. It is 00 in IDLE.
- start while busy is ignored, not queued.
- Strobe outputs are Moore decodes of the state register plus op_q. illegal is a registered output.
- Reset, including mid-operation: on the rst edge go to IDLE.
  - op_q=0, bit_idx=0.
  - Every output is 0 in the cycle after the rst edge.
  - A start in the same cycle as rst is dropped.
- The counter never wraps outside EXEC. bit_idx is 0 in every state except EXEC.

Optional Feature:
Macro CTRL_STEP_EN, for single-step debug.
- Defined:
  - Adds input step (1 bit, placed after opcode), normally driven by the debounced button edge.
  - In EXEC, shift_en=step, carry_en is gated by step, and bit_idx advances only on step.
  - The EXEC->WRITE transition needs step=1 at bit_idx==WIDTH-1.
  - All other states are unaffected.
- Undefined: no step port; EXEC advances every cycle as above.

Test Plan:
1. WIDTH=8, start with opcode 0000 at edge 0 -> load_a in cycle 1; load_b in cycle 2 with imm_sel=0, carry_init=1, carry_val=0; shift_en and carry_en in cycles 3-10 with bit_idx 0..7; load_out and done in cycle 11; busy in cycles 1-11.
2. Opcode 1001 (SUBI) -> imm_sel=1 and carry_val=1 in LOAD_B; invert_b=1 and alu_op=00 through EXEC; done in cycle 11.
3. Opcode 0111 -> illegal=1 in cycle 1 only; busy, load_a and done stay 0; a following start with 0110 runs with alu_op=01 and carry_en=0.
4. start pulsed again in cycle 5 of an active op -> ignored, done only once in cycle 11; start in cycle 12 is accepted, load_a in cycle 13.
5. rst asserted in the EXEC cycle with bit_idx=3 -> next cycle IDLE, all outputs 0; a new start then completes normally in WIDTH+3 cycles.
6. CTRL_STEP_EN with step=1 every third cycle in EXEC -> bit_idx advances only on step cycles; WRITE follows the 8th step; shift_en count is exactly 8.
